// File: rtl/pixel_grid_sampler.sv
// Captures a byte-serial frame of 16-bit pixels and keeps the pixels found on a
// GRID x GRID lattice of sample points in a small register memory.
module pixel_grid_sampler #(
    parameter int unsigned LINES    = 120,
    parameter int unsigned COLUMNS  = 320,
    parameter int unsigned GRID     = 3,
    parameter int unsigned S_LINE   = 7,
    parameter int unsigned S_COLUMN = 9,
    parameter int unsigned HI_FIRST = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic [3:0]  rd_line,
    input  logic [3:0]  rd_column,
    output logic [15:0] rd_pixel,
    output logic        busy,
    output logic        done,
    output logic [7:0]  sample_count
);

    localparam int unsigned CELLS  = GRID * GRID;
    localparam int unsigned ADDR_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned KW     = (GRID > 1) ? $clog2(GRID) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FIRST,
        WAIT_SECOND,
        ADVANCE,
        FINISH
    } state_t;

    // Position of the k-th sample along an axis of length dim (centre of k-th band).
    function automatic int unsigned sample_pos(input int unsigned k, input int unsigned dim);
        return ((2 * k + 1) * dim) / (2 * GRID);
    endfunction

    state_t              state_q, state_d;
    logic [S_LINE-1:0]   line_q, line_d;
    logic [S_COLUMN-1:0] column_q, column_d;
    logic [7:0]          first_q, first_d;
    logic [15:0]         pixel_q, pixel_d;
    logic [7:0]          count_q, count_d;
    logic                busy_q, done_q;
    logic [15:0]         mem_q [CELLS];

    logic                row_hit, col_hit, wr_en;
    logic [KW-1:0]       row_k, col_k;
    logic [ADDR_W-1:0]   wr_addr, rd_addr;

    // Sample-point decode of the current counter position
    always_comb begin
        row_hit = 1'b0;
        col_hit = 1'b0;
        row_k   = '0;
        col_k   = '0;
        for (int unsigned k = 0; k < GRID; k++) begin
            if (32'(line_q) == sample_pos(k, LINES)) begin
                row_hit = 1'b1;
                row_k   = KW'(k);
            end
            if (32'(column_q) == sample_pos(k, COLUMNS)) begin
                col_hit = 1'b1;
                col_k   = KW'(k);
            end
        end
        wr_addr = ADDR_W'(32'(row_k) * GRID + 32'(col_k));
    end

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        column_d = column_q;
        first_d  = first_q;
        pixel_d  = pixel_q;
        count_d  = count_q;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WAIT_FIRST;
                    line_d   = '0;
                    column_d = '0;
                    count_d  = '0;
                end
            end
            WAIT_FIRST: begin
                if (byte_valid) begin
                    first_d = byte_data;
                    state_d = WAIT_SECOND;
                end
            end
            WAIT_SECOND: begin
                if (byte_valid) begin
                    pixel_d = (HI_FIRST != 0) ? {first_q, byte_data} : {byte_data, first_q};
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (row_hit && col_hit) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 8'd1;
                end
                state_d = WAIT_FIRST;
                if (column_q == S_COLUMN'(COLUMNS - 1)) begin
                    column_d = '0;
                    if (line_q == S_LINE'(LINES - 1)) begin
                        state_d = FINISH;
                    end else begin
                        line_d = line_q + S_LINE'(1);
                    end
                end else begin
                    column_d = column_q + S_COLUMN'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            line_q   <= '0;
            column_q <= '0;
            first_q  <= '0;
            pixel_q  <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int unsigned i = 0; i < CELLS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            column_q <= column_d;
            first_q  <= first_d;
            pixel_q  <= pixel_d;
            count_q  <= count_d;
            busy_q   <= (state_d == WAIT_FIRST) || (state_d == WAIT_SECOND) || (state_d == ADVANCE);
            done_q   <= (state_d == FINISH);
            if (wr_en) begin
                mem_q[wr_addr] <= pixel_q;
            end
        end
    end

    // Read port sees the registered memory, so a same-cycle write shows up one cycle later
    always_comb begin
        rd_addr  = ADDR_W'(32'(rd_line) * GRID + 32'(rd_column));
        rd_pixel = 16'h0000;
        if ((32'(rd_line) < GRID) && (32'(rd_column) < GRID)) begin
            rd_pixel = mem_q[rd_addr];
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_pixel_grid_sampler.sv
// Randomized bench: two samplers (high-byte-first and low-byte-first) share one
// byte stream and are compared against a frame/grid model kept here.
module tb_pixel_grid_sampler;

    localparam int TL = 12;
    localparam int TC = 20;
    localparam int TG = 3;
    localparam int NC = TG * TG;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, bv;
    logic [7:0]  bd;
    logic [3:0]  rd_line, rd_column;
    logic [15:0] a_pix, b_pix;
    logic        a_busy, a_done, b_busy, b_done;
    logic [7:0]  a_cnt, b_cnt;

    pixel_grid_sampler #(.LINES(TL), .COLUMNS(TC), .GRID(TG), .S_LINE(7), .S_COLUMN(9), .HI_FIRST(1)) dut_a (
        .clock(clk), .reset(rst), .start(start), .byte_valid(bv), .byte_data(bd),
        .rd_line(rd_line), .rd_column(rd_column), .rd_pixel(a_pix),
        .busy(a_busy), .done(a_done), .sample_count(a_cnt)
    );

    pixel_grid_sampler #(.LINES(TL), .COLUMNS(TC), .GRID(TG), .S_LINE(7), .S_COLUMN(9), .HI_FIRST(0)) dut_b (
        .clock(clk), .reset(rst), .start(start), .byte_valid(bv), .byte_data(bd),
        .rd_line(rd_line), .rd_column(rd_column), .rd_pixel(b_pix),
        .busy(b_busy), .done(b_done), .sample_count(b_cnt)
    );

    int checks = 0;
    int errors = 0;
    int na = 0;
    int nb = 0;
    logic [15:0] exp_a [NC];
    logic [15:0] exp_b [NC];
    int exp_cnt;
    int rd_addr;

    always @(negedge clk) begin
        if (a_done) na++;
        if (b_done) nb++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Grid index of a coordinate, or -1 when it is not a sample position
    function automatic int samp_k(input int pos, input int dim);
        for (int k = 0; k < TG; k++) begin
            if (pos == ((2 * k + 1) * dim) / (2 * TG)) return k;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int addr);
        rd_line   = 4'(addr / TG);
        rd_column = 4'(addr % TG);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NC; i++) begin
            exp_a[i] = 16'h0000;
            exp_b[i] = 16'h0000;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NC; i++) begin
            set_rd(i);
            #1;
            check_eq({tag, "_a"}, 32'(a_pix), 32'(exp_a[i]));
            check_eq({tag, "_b"}, 32'(b_pix), 32'(exp_b[i]));
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        bv = 1'b1;
        bd = d;
        tick();
        bv = 1'b0;
        bd = 8'($urandom);
    endtask

    task automatic send_pixel(input int line, input int col, input logic [7:0] b1,
                              input logic [7:0] b2, input bit inject);
        int kr, kc, addr;
        bit hit;
        kr   = samp_k(line, TL);
        kc   = samp_k(col, TC);
        hit  = (kr >= 0) && (kc >= 0);
        addr = hit ? kr * TG + kc : -1;
        send_byte(b1);
        repeat ($urandom_range(1, 3)) tick();
        send_byte(b2);
        if (hit && addr == rd_addr) begin
            @(negedge clk);
            check_eq("rd_old_a", 32'(a_pix), 32'(exp_a[addr]));
            check_eq("rd_old_b", 32'(b_pix), 32'(exp_b[addr]));
        end
        if (inject) begin
            bv    = 1'b1;
            bd    = 8'($urandom);
            start = 1'b1;
        end
        tick();
        bv    = 1'b0;
        start = 1'b0;
        if (hit) begin
            exp_a[addr] = {b1, b2};
            exp_b[addr] = {b2, b1};
            exp_cnt++;
            if (addr == rd_addr) begin
                @(negedge clk);
                check_eq("rd_new_a", 32'(a_pix), 32'(exp_a[addr]));
                check_eq("rd_new_b", 32'(b_pix), 32'(exp_b[addr]));
            end
        end
        if (inject) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    // mode 0: {line,col} pattern, 1: 12/34 at sample points, 2: random, 3: random + injected strobes
    task automatic run_frame(input int mode, input int abort_at);
        int da, db, idx;
        logic [7:0] b1, b2;
        logic [15:0] v;
        bit last;
        rd_addr = $urandom_range(0, NC - 1);
        set_rd(rd_addr);
        exp_cnt = 0;
        da = na;
        db = nb;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check_eq("busy_start", 32'(a_busy), 32'd1);
        check_eq("keep_a", 32'(a_pix), 32'(exp_a[rd_addr]));
        check_eq("keep_b", 32'(b_pix), 32'(exp_b[rd_addr]));
        check_eq("cnt_clear", 32'(a_cnt), 32'd0);
        idx = 0;
        for (int line = 0; line < TL; line++) begin
            for (int col = 0; col < TC; col++) begin
                if (abort_at > 0 && idx == abort_at) begin
                    check_eq("abort_no_done", 32'(na - da), 32'd0);
                    rst   = 1'b1;
                    start = 1'b1;
                    bv    = 1'b1;
                    tick();
                    rst   = 1'b0;
                    start = 1'b0;
                    bv    = 1'b0;
                    clear_model();
                    @(negedge clk);
                    check_eq("abort_busy", 32'(a_busy), 32'd0);
                    check_eq("abort_done", 32'(a_done | b_done), 32'd0);
                    check_eq("abort_cnt", 32'(a_cnt), 32'd0);
                    check_all("abort_clear");
                    repeat (4) tick();
                    check_eq("abort_no_done_after", 32'(na - da + nb - db), 32'd0);
                    check_eq("abort_idle", 32'(a_busy), 32'd0);
                    return;
                end
                case (mode)
                    0: begin
                        v  = {8'(line), 8'(col)};
                        b1 = v[15:8];
                        b2 = v[7:0];
                    end
                    1: begin
                        if (samp_k(line, TL) >= 0 && samp_k(col, TC) >= 0) begin
                            b1 = 8'h12;
                            b2 = 8'h34;
                        end else begin
                            b1 = 8'($urandom);
                            b2 = 8'($urandom);
                        end
                    end
                    default: begin
                        b1 = 8'($urandom);
                        b2 = 8'($urandom);
                    end
                endcase
                last = (line == TL - 1) && (col == TC - 1);
                if (last) check_eq("no_early_done", 32'(na - da), 32'd0);
                send_pixel(line, col, b1, b2, (mode == 3) && !last && ($urandom_range(0, 3) == 0));
                idx++;
            end
        end
        @(negedge clk);
        check_eq("done_pulse_a", 32'(a_done), 32'd1);
        check_eq("done_pulse_b", 32'(b_done), 32'd1);
        check_eq("busy_finish", 32'(a_busy), 32'd0);
        tick();
        @(negedge clk);
        check_eq("done_clear", 32'(a_done | b_done), 32'd0);
        check_eq("busy_idle", 32'(a_busy | b_busy), 32'd0);
        check_eq("done_count_a", 32'(na - da), 32'd1);
        check_eq("done_count_b", 32'(nb - db), 32'd1);
        check_eq("sample_count_a", 32'(a_cnt), 32'(exp_cnt));
        check_eq("sample_count_b", 32'(b_cnt), 32'(exp_cnt));
        check_all("frame");
        rd_line = 4'd3; rd_column = 4'd0; #1;
        check_eq("oob_3_0", 32'(a_pix), 32'd0);
        rd_line = 4'd0; rd_column = 4'd15; #1;
        check_eq("oob_0_15", 32'(b_pix), 32'd0);
        rd_line = 4'($urandom_range(TG, 15)); rd_column = 4'($urandom_range(0, 15)); #1;
        check_eq("oob_rand", 32'(a_pix), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        bv    = 1'b0;
        bd    = 8'h00;
        set_rd(0);
        clear_model();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_busy", 32'(a_busy | b_busy), 32'd0);
        check_eq("reset_done", 32'(a_done | b_done), 32'd0);
        check_eq("reset_cnt", 32'(a_cnt), 32'd0);
        check_all("reset");

        run_frame(0, 0);
        run_frame(1, 0);
        for (int i = 0; i < NC; i++) begin
            set_rd(i);
            #1;
            check_eq("lo_first_3412", 32'(b_pix), 32'h3412);
        end
        run_frame(2, 100);
        run_frame(2, 0);
        run_frame(3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_grid_sampler.md
PIXEL_GRID_SAMPLER -- requirements
Module: pixel_grid_sampler

Interface
REQ-001 The block SHALL have these parameters: LINES, 120, frame height in pixels; COLUMNS, 320, frame width in pixels; GRID, 3, sample grid is GRID x GRID; S_LINE, 7, line counter width; S_COLUMN, 9, column counter width; HI_FIRST, 1, 1 = high byte of pixel arrives first.
REQ-002 The block SHALL have these ports: clock in 1, system clock; reset in 1, synchronous active-high reset.
REQ-003 The block SHALL have these ports: start in 1, begin frame capture; byte_valid in 1, one-cycle strobe from serial receiver; byte_data in 8, received byte.
REQ-004 The block SHALL have these ports: rd_line in 4, grid row to read; rd_column in 4, grid column to read; rd_pixel out 16, stored sample.
REQ-005 The block SHALL have these ports: busy out 1, capture in progress; done out 1, one-cycle end-of-frame pulse; sample_count out 8, samples written this frame.
REQ-006 All logic SHALL run on one clock, with reset synchronous and active-high; no other clock or asynchronous clear.

Function
REQ-007 The FSM SHALL have states IDLE, WAIT_FIRST, WAIT_SECOND, ADVANCE, FINISH.
REQ-008 IDLE SHALL go to WAIT_FIRST when start=1, clearing the line counter, column counter and sample_count that same cycle; start SHALL be ignored in every other state.
REQ-009 WAIT_FIRST SHALL latch byte_data into the first-byte register on byte_valid=1 and go to WAIT_SECOND; with no strobe it SHALL hold.
REQ-010 WAIT_SECOND SHALL assemble the 16-bit pixel on byte_valid=1: {first, byte_data} if HI_FIRST=1, else {byte_data, first}; it SHALL then go to ADVANCE.
REQ-011 ADVANCE SHALL last exactly one cycle: it SHALL write the pixel if it is a sample point, then advance the counters.
  - column < COLUMNS-1: column+1.
  - column = COLUMNS-1: column=0, line+1.
  - last pixel (line=LINES-1, column=COLUMNS-1): go to FINISH instead of WAIT_FIRST.
REQ-012 Sample rows SHALL be line = (2k+1)*LINES/(2*GRID), k=0..GRID-1, using integer division evaluated at elaboration; sample columns SHALL use the same formula with COLUMNS. Defaults give rows 20,60,100 and columns 53,160,266.
REQ-013 A sample point SHALL be any (line,column) where both match; write address SHALL be k_row*GRID + k_col, and sample_count SHALL increment by 1 per write.
REQ-014 A byte_valid arriving in ADVANCE, FINISH or IDLE SHALL be dropped; the upstream UART rate guarantees at least 2 cycles between strobes.
REQ-015 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-016 busy SHALL be 1 in WAIT_FIRST, WAIT_SECOND and ADVANCE, and 0 in IDLE and FINISH.
REQ-017 Sample memory SHALL be GRID*GRID x 16 bits; rd_pixel SHALL be a combinational read of mem[rd_line*GRID+rd_column].
REQ-018 rd_pixel SHALL be 16'h0000 when rd_line >= GRID or rd_column >= GRID.
REQ-019 A new frame SHALL overwrite entries only as they are sampled; memory SHALL NOT be cleared by start.
REQ-020 A same-cycle read and write of one address SHALL return the old value; the new value SHALL appear the next cycle.

Reset
REQ-021 On reset=1 at a clock edge the FSM SHALL enter IDLE; counters, first-byte register and sample_count SHALL be 0; busy=0, done=0; every memory entry SHALL be 16'h0000.
REQ-022 Reset SHALL override start and byte_valid in the same cycle, and reset mid-frame SHALL abandon the frame with no done pulse.

Verification
REQ-023 Reset then read all 9 addresses -> rd_pixel=0000, busy=0, done=0, sample_count=0.
REQ-024 Start, then stream 320x120 pixels with value {line[7:0],column[7:0]}, HI_FIRST=1 -> done pulses once 1 cycle after the last ADVANCE; sample_count=9; (0,0)=1435; (1,1)=3CA0; (2,2)=640A.
REQ-025 Run with HI_FIRST=0 and byte pairs 12,34 at every sample point -> all 9 entries read 3412.
REQ-026 Assert reset after 10000 pixels, then start a full frame -> no done before reset; the second frame completes normally; entries hold second-frame values.
REQ-027 Pulse start mid-frame and inject byte_valid during ADVANCE -> no counter restart, the extra byte is dropped, the pixel count is unchanged.
REQ-028 Read rd_line=3, rd_column=0 after a frame, and rd_line=0, rd_column=15 -> rd_pixel=0000.
